// File: rtl/lr35902_vmem_arbiter.sv
// lr35902_vmem_arbiter
//   Sequences the single-port VRAM and OAM between PPU, OAM DMA and the CPU
//   bus. Each resource has its own owner FSM (IDLE/PPU/DMA/CPU/TURN) with
//   priority PPU > DMA > CPU, registered grants, optional dead cycle on every
//   hand-off and read-data return tagging (RAMs have 1-cycle read latency).
//
// Ports
//   clk, reset          gbclk domain, synchronous active-high reset
//   ppu_*               PPU ownership requests, address, read strobe
//   dma_*               OAM DMA: VRAM-sourced reads, OAM writes, dma_rdata
//   cpu_*               CPU bus decodes, strobes, wdata, cpu_rdata
//   vram_*, oam_*       RAM macro ports (combinational from registered owner)
//   gnt_vram, gnt_oam   owner code: 0 none, 1 PPU, 2 DMA, 3 CPU
//   cpu_denied          high in every cycle a CPU access is refused
//
// Build option
//   GB_ARB_WRBUF_EN     one-entry posted CPU write buffer per resource with
//                       read forwarding; undefined = denied writes are lost.

module lr35902_vmem_owner #(
   parameter int TURNAROUND = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_ppu,
   input  logic       req_dma,
   input  logic       req_cpu,
   input  logic       wb_pend,
   output logic [1:0] gnt,
   output logic       retire
);
   typedef enum logic [2:0] {S_IDLE, S_PPU, S_DMA, S_CPU, S_TURN} state_t;

   state_t     state, pend, nxt;
   logic       wbp, pend_ret, nxt_ret;
   logic [1:0] gnt_n;

   always_comb begin
      // the buffer entry being retired this cycle is no longer pending
      wbp      = wb_pend && !retire;
      pend     = S_IDLE;
      pend_ret = 1'b0;
      if (req_ppu)      pend = S_PPU;
      else if (req_dma) pend = S_DMA;
      else if (req_cpu) pend = S_CPU;
      else if (wbp) begin
         pend     = S_CPU;
         pend_ret = 1'b1;
      end
      // default: owner leaves (dropped or preempted)
      nxt     = (TURNAROUND != 0) ? S_TURN : pend;
      nxt_ret = (TURNAROUND != 0) ? 1'b0   : pend_ret;
      unique case (state)
         S_IDLE, S_TURN: begin
            nxt     = pend;
            nxt_ret = pend_ret;
         end
         S_PPU: if (req_ppu) begin
            nxt     = S_PPU;
            nxt_ret = 1'b0;
         end
         S_DMA: if (req_dma && !req_ppu) begin
            nxt     = S_DMA;
            nxt_ret = 1'b0;
         end
         S_CPU: if (req_cpu && !req_ppu && !req_dma && !retire) begin
            nxt     = S_CPU;
            nxt_ret = 1'b0;
         end
         default: begin
            nxt     = S_IDLE;
            nxt_ret = 1'b0;
         end
      endcase
      unique case (nxt)
         S_PPU:   gnt_n = 2'd1;
         S_DMA:   gnt_n = 2'd2;
         S_CPU:   gnt_n = 2'd3;
         default: gnt_n = 2'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         gnt    <= 2'd0;
         retire <= 1'b0;
      end else begin
         state  <= nxt;
         gnt    <= gnt_n;
         retire <= nxt_ret;
      end
   end
endmodule

module lr35902_vmem_arbiter #(
   parameter int VRAM_AW    = 13,
   parameter int OAM_AW     = 8,
   parameter int TURNAROUND = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ppu_need_vram,
   input  logic               ppu_need_oam,
   input  logic [15:0]        ppu_adr,
   input  logic               ppu_rd,
   input  logic               dma_active,
   input  logic               dma_src_vram,
   input  logic [15:0]        dma_adr_rd,
   input  logic               dma_rd,
   input  logic [7:0]         dma_adr_wr,
   input  logic               dma_wr,
   input  logic [7:0]         dma_wdata,
   output logic [7:0]         dma_rdata,
   input  logic               cpu_sel_vram,
   input  logic               cpu_sel_oam,
   input  logic [15:0]        cpu_adr,
   input  logic               cpu_rd,
   input  logic               cpu_wr,
   input  logic [7:0]         cpu_wdata,
   output logic [7:0]         cpu_rdata,
   output logic [VRAM_AW-1:0] vram_adr,
   output logic               vram_rd,
   output logic               vram_wr,
   output logic [7:0]         vram_din,
   input  logic [7:0]         vram_dout,
   output logic [OAM_AW-1:0]  oam_adr,
   output logic               oam_rd,
   output logic               oam_wr,
   output logic [7:0]         oam_din,
   input  logic [7:0]         oam_dout,
   output logic [1:0]         gnt_vram,
   output logic [1:0]         gnt_oam,
   output logic               cpu_denied
);
   localparam logic [1:0] OWN_PPU = 2'd1;
   localparam logic [1:0] OWN_DMA = 2'd2;
   localparam logic [1:0] OWN_CPU = 2'd3;

   logic              req_v_ppu, req_v_dma, req_v_cpu;
   logic              req_o_ppu, req_o_dma, req_o_cpu;
   logic [1:0]        own_v, own_o, rtag_v, rtag_o;
   logic              ret_v, ret_o, deny_v, deny_o;
   logic [15:0]       dma_wa;
   logic              wbv_vld, wbo_vld, fwd_vld;
   logic [VRAM_AW-1:0] wbv_adr;
   logic [OAM_AW-1:0] wbo_adr;
   logic [7:0]        wbv_data, wbo_data, fwd_data;
   logic              unused_ok;

   assign unused_ok = ^{ppu_adr, cpu_adr, dma_adr_rd};
   assign dma_wa    = {8'h00, dma_adr_wr};

   // both decodes high is illegal; VRAM takes it
   assign req_v_ppu = ppu_need_vram;
   assign req_v_dma = dma_active && dma_src_vram;
   assign req_v_cpu = cpu_sel_vram && (cpu_rd || cpu_wr);
   assign req_o_ppu = ppu_need_oam;
   assign req_o_dma = dma_active;
   assign req_o_cpu = cpu_sel_oam && !cpu_sel_vram && (cpu_rd || cpu_wr);

   lr35902_vmem_owner #(.TURNAROUND(TURNAROUND)) u_own_vram (
      .clk(clk), .reset(reset), .req_ppu(req_v_ppu), .req_dma(req_v_dma),
      .req_cpu(req_v_cpu), .wb_pend(wbv_vld), .gnt(own_v), .retire(ret_v));

   lr35902_vmem_owner #(.TURNAROUND(TURNAROUND)) u_own_oam (
      .clk(clk), .reset(reset), .req_ppu(req_o_ppu), .req_dma(req_o_dma),
      .req_cpu(req_o_cpu), .wb_pend(wbo_vld), .gnt(own_o), .retire(ret_o));

   assign gnt_vram = reset ? 2'd0 : own_v;
   assign gnt_oam  = reset ? 2'd0 : own_o;

   // Refused = resource held by someone else (or busy retiring the buffer).
   // IDLE/TURN cycles are the CPU waiting for its grant, not a refusal.
   assign deny_v     = req_v_cpu && (own_v == OWN_PPU || own_v == OWN_DMA || ret_v);
   assign deny_o     = req_o_cpu && (own_o == OWN_PPU || own_o == OWN_DMA || ret_o);
   assign cpu_denied = !reset && (deny_v || deny_o);

   // Strobes are qualified by the owner's live request so a request that
   // drops while the grant is still registered never reaches the RAM.
   always_comb begin
      vram_adr = '0; vram_rd = 1'b0; vram_wr = 1'b0; vram_din = 8'h00;
      if (!reset) begin
         unique case (own_v)
            OWN_PPU: begin
               vram_adr = ppu_adr[VRAM_AW-1:0];
               vram_rd  = ppu_rd && req_v_ppu;
            end
            OWN_DMA: begin
               vram_adr = dma_adr_rd[VRAM_AW-1:0];
               vram_rd  = dma_rd && req_v_dma;
            end
            OWN_CPU: if (ret_v) begin
               vram_adr = wbv_adr;
               vram_wr  = 1'b1;
               vram_din = wbv_data;
            end else begin
               vram_adr = cpu_adr[VRAM_AW-1:0];
               vram_rd  = cpu_rd && req_v_cpu;
               vram_wr  = cpu_wr && req_v_cpu;
               vram_din = cpu_wdata;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      oam_adr = '0; oam_rd = 1'b0; oam_wr = 1'b0; oam_din = 8'h00;
      if (!reset) begin
         unique case (own_o)
            OWN_PPU: begin
               oam_adr = ppu_adr[OAM_AW-1:0];
               oam_rd  = ppu_rd && req_o_ppu;
            end
            OWN_DMA: begin
               oam_adr = dma_wa[OAM_AW-1:0];
               oam_wr  = dma_wr && req_o_dma;
               oam_din = dma_wdata;
            end
            OWN_CPU: if (ret_o) begin
               oam_adr = wbo_adr;
               oam_wr  = 1'b1;
               oam_din = wbo_data;
            end else begin
               oam_adr = cpu_adr[OAM_AW-1:0];
               oam_rd  = cpu_rd && req_o_cpu;
               oam_wr  = cpu_wr && req_o_cpu;
               oam_din = cpu_wdata;
            end
            default: ;
         endcase
      end
   end

   // tag each issued read with its owner; data comes back next cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         rtag_v <= 2'd0;
         rtag_o <= 2'd0;
      end else begin
         rtag_v <= vram_rd ? own_v : 2'd0;
         rtag_o <= oam_rd  ? own_o : 2'd0;
      end
   end

   assign dma_rdata = (!reset && rtag_v == OWN_DMA) ? vram_dout : 8'hFF;

   // forwarded buffer data wins over RAM, whose copy is stale until retire
   always_comb begin
      cpu_rdata = 8'hFF;
      if (!reset) begin
         if (fwd_vld)                cpu_rdata = fwd_data;
         else if (rtag_v == OWN_CPU) cpu_rdata = vram_dout;
         else if (rtag_o == OWN_CPU) cpu_rdata = oam_dout;
      end
   end

`ifdef GB_ARB_WRBUF_EN
   logic cap_v, cap_o, hit_v, hit_o;

   assign cap_v = deny_v && cpu_wr && !wbv_vld;
   assign cap_o = deny_o && cpu_wr && !wbo_vld;
   assign hit_v = req_v_cpu && cpu_rd && wbv_vld && (cpu_adr[VRAM_AW-1:0] == wbv_adr);
   assign hit_o = req_o_cpu && cpu_rd && wbo_vld && (cpu_adr[OAM_AW-1:0] == wbo_adr);

   always_ff @(posedge clk) begin
      if (reset) begin
         wbv_vld <= 1'b0;
         wbo_vld <= 1'b0;
         fwd_vld <= 1'b0;
      end else begin
         if (ret_v)      wbv_vld <= 1'b0;
         else if (cap_v) wbv_vld <= 1'b1;
         if (ret_o)      wbo_vld <= 1'b0;
         else if (cap_o) wbo_vld <= 1'b1;
         fwd_vld <= hit_v || hit_o;
      end
   end

   // payload only meaningful while valid, so no reset
   always_ff @(posedge clk) begin
      if (cap_v) begin
         wbv_adr  <= cpu_adr[VRAM_AW-1:0];
         wbv_data <= cpu_wdata;
      end
      if (cap_o) begin
         wbo_adr  <= cpu_adr[OAM_AW-1:0];
         wbo_data <= cpu_wdata;
      end
      fwd_data <= hit_v ? wbv_data : wbo_data;
   end
`else
   assign wbv_vld  = 1'b0;
   assign wbo_vld  = 1'b0;
   assign wbv_adr  = '0;
   assign wbo_adr  = '0;
   assign wbv_data = 8'h00;
   assign wbo_data = 8'h00;
   assign fwd_vld  = 1'b0;
   assign fwd_data = 8'hFF;
`endif
endmodule
